// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART tx byte port.
// An optional header byte (HEADER_BASE | index) precedes each packet.
module uart_tx_arbiter #(
  parameter int         NUM_REQUESTERS = 4,
  parameter bit         HEADER_ENABLE  = 1'b1,
  parameter logic [7:0] HEADER_BASE    = 8'hF0
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [8*NUM_REQUESTERS-1:0] i_req_data,
  input  logic [NUM_REQUESTERS-1:0]   i_req_valid,
  input  logic [NUM_REQUESTERS-1:0]   i_req_last,
  output logic [NUM_REQUESTERS-1:0]   o_req_ready,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_data_valid,
  input  logic                        i_tx_data_ready,
  output logic [NUM_REQUESTERS-1:0]   o_grant,
  output logic                        o_busy
);
  localparam int N    = NUM_REQUESTERS;
  localparam int ID_W = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD
  } state_e;

  state_e          state_q;
  logic [ID_W-1:0] idx_q;
  logic [ID_W-1:0] last_q;
  logic [N-1:0]    grant_q;
  logic [7:0]      data_q;
  logic            valid_q;

  logic            slot_free;
  logic            sel_valid;
  logic            sel_last;
  logic            xfer;
  logic [7:0]      sel_data;
  logic [ID_W:0]   cand;
  logic [ID_W-1:0] pick_d;
  logic            pick_vld_d;

  assign slot_free = !valid_q || i_tx_data_ready;
  assign sel_valid = |(i_req_valid & grant_q);
  assign sel_last  = |(i_req_last & grant_q);
  assign xfer      = (state_q == S_PAYLOAD) && slot_free && sel_valid;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_q[k]) sel_data = i_req_data[8*k +: 8];
    end
  end

  // Scan farthest-first so the nearest valid index after last_q wins.
  always_comb begin
    pick_d     = '0;
    pick_vld_d = 1'b0;
    cand       = '0;
    for (int off = N; off >= 1; off--) begin
      cand = {1'b0, last_q} + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(N)) cand = cand - (ID_W+1)'(N);
      if (i_req_valid[cand[ID_W-1:0]]) begin
        pick_d     = cand[ID_W-1:0];
        pick_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= ID_W'(N - 1);
      grant_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && i_tx_data_ready) valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            idx_q   <= pick_d;
            grant_q <= {{(N-1){1'b0}}, 1'b1} << pick_d;
            state_q <= HEADER_ENABLE ? S_HEADER : S_PAYLOAD;
          end
        end
        S_HEADER: begin
          if (slot_free) begin
            data_q  <= HEADER_BASE | {{(8-ID_W){1'b0}}, idx_q};
            valid_q <= 1'b1;
            state_q <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            data_q  <= sel_data;
            valid_q <= 1'b1;
            if (sel_last) begin
              state_q <= S_IDLE;
              grant_q <= '0;
              last_q  <= idx_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready     = (state_q == S_PAYLOAD && slot_free) ? grant_q : '0;
  assign o_tx_data       = data_q;
  assign o_tx_data_valid = valid_q;
  assign o_grant         = grant_q;
  assign o_busy          = (state_q != S_IDLE) || valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed plus randomized checks of two arbiters,
// one with headers (index 0) and one payload-only (index 1).
module tb_uart_tx_arbiter;
  logic        clk;
  logic        rst;
  logic [31:0] req_data  [2];
  logic [3:0]  req_valid [2];
  logic [3:0]  req_last  [2];
  logic [3:0]  req_ready [2];
  logic [7:0]  tx_data   [2];
  logic        tx_valid  [2];
  logic        tx_ready  [2];
  logic [3:0]  grant     [2];
  logic        busy      [2];

  logic [8:0]  src_q [8][$];
  logic [7:0]  exp_q [2][$];
  bit          en    [8];
  bit          rdy_rand [2];
  bit          rdy_val  [2];
  bit          prev_stall [2];
  logic [7:0]  prev_data  [2];
  int          rr_ptr [2];
  int          checks;
  int          errors;

  uart_tx_arbiter #(
    .NUM_REQUESTERS(4),
    .HEADER_ENABLE(1'b1),
    .HEADER_BASE(8'hF0)
  ) u_hdr (
    .i_clock(clk),
    .i_reset(rst),
    .i_req_data(req_data[0]),
    .i_req_valid(req_valid[0]),
    .i_req_last(req_last[0]),
    .o_req_ready(req_ready[0]),
    .o_tx_data(tx_data[0]),
    .o_tx_data_valid(tx_valid[0]),
    .i_tx_data_ready(tx_ready[0]),
    .o_grant(grant[0]),
    .o_busy(busy[0])
  );

  uart_tx_arbiter #(
    .NUM_REQUESTERS(4),
    .HEADER_ENABLE(1'b0),
    .HEADER_BASE(8'hF0)
  ) u_nohdr (
    .i_clock(clk),
    .i_reset(rst),
    .i_req_data(req_data[1]),
    .i_req_valid(req_valid[1]),
    .i_req_last(req_last[1]),
    .o_req_ready(req_ready[1]),
    .o_tx_data(tx_data[1]),
    .o_tx_data_valid(tx_valid[1]),
    .i_tx_data_ready(tx_ready[1]),
    .o_grant(grant[1]),
    .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        if (en[d*4+k] && src_q[d*4+k].size() > 0) begin
          req_valid[d][k]      = 1'b1;
          req_data[d][8*k +: 8] = src_q[d*4+k][0][7:0];
          req_last[d][k]       = src_q[d*4+k][0][8];
        end else begin
          req_valid[d][k]      = 1'b0;
          req_data[d][8*k +: 8] = 8'($urandom);
          req_last[d][k]       = 1'($urandom);
        end
      end
      tx_ready[d] = rdy_rand[d] ? ($urandom_range(0, 3) != 0) : rdy_val[d];
    end
  endtask

  // Packet-level round robin over whatever the sources currently hold.
  function automatic void build_expected(input int d);
    logic [8:0] q [4][$];
    logic [8:0] b;
    int pick;
    for (int k = 0; k < 4; k++) q[k] = src_q[d*4+k];
    while (1) begin
      pick = -1;
      for (int off = 1; off <= 4; off++) begin
        if (pick < 0 && q[(rr_ptr[d] + off) % 4].size() > 0)
          pick = (rr_ptr[d] + off) % 4;
      end
      if (pick < 0) break;
      if (d == 0) exp_q[d].push_back(8'hF0 | 8'(pick));
      do begin
        b = q[pick].pop_front();
        exp_q[d].push_back(b[7:0]);
      end while (!b[8] && q[pick].size() > 0);
      rr_ptr[d] = pick;
    end
  endfunction

  task automatic tick();
    logic [3:0] fire [2];
    logic [8:0] e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      fire[d] = '0;
      if (rst) begin
        prev_stall[d] = 1'b0;
      end else begin
        if (prev_stall[d])
          chk($sformatf("hold%0d", d), {tx_valid[d], tx_data[d]},
              {1'b1, prev_data[d]});
        if (tx_valid[d] && tx_ready[d]) begin
          e = (exp_q[d].size() > 0) ? {1'b0, exp_q[d].pop_front()} : 9'h100;
          chk($sformatf("stream%0d", d), {1'b0, tx_data[d]}, e);
        end
        prev_stall[d] = tx_valid[d] && !tx_ready[d];
        prev_data[d]  = tx_data[d];
        fire[d]       = req_valid[d] & req_ready[d];
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        if (fire[d][k]) void'(src_q[d*4+k].pop_front());
    drive();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_left"}, exp_q[0].size() + exp_q[1].size(), 0);
    chk({tag, "_busy"}, {busy[1], busy[0]}, 0);
  endtask

  initial begin
    int n;
    int tot;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) en[i] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rdy_rand[d]   = 1'b0;
      rdy_val[d]    = 1'b1;
      prev_stall[d] = 1'b0;
      rr_ptr[d]     = 3;
    end
    rst = 1'b1;
    drive();
    tick();
    tick();
    chk("rst_valid", tx_valid[0], 0);
    chk("rst_data", tx_data[0], 8'h00);
    chk("rst_grant", grant[0], 0);
    chk("rst_ready", req_ready[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_grant_nh", grant[1], 0);
    rst = 1'b0;

    // Single 3-byte packet from requester 2.
    src_q[2] = '{9'h041, 9'h042, 9'h143};
    build_expected(0);
    drive();
    tick();
    chk("p2_grant_lat", grant[0], 4'b0100);
    tick();
    chk("p2_hdr", {tx_valid[0], tx_data[0]}, 9'h1F2);
    chk("p2_grant", grant[0], 4'b0100);
    tick();
    tick();
    tick();
    chk("p2_last", {tx_valid[0], tx_data[0]}, 9'h143);
    chk("p2_grant_clr", grant[0], 0);
    chk("p2_busy_hi", busy[0], 1);
    tick();
    chk("p2_busy_lo", busy[0], 0);
    drain("p2");

    // Requesters 0 and 1 contend with repeated 1-byte packets.
    src_q[0] = '{9'h1AA, 9'h1AA, 9'h1AA};
    src_q[1] = '{9'h1BB, 9'h1BB, 9'h1BB};
    build_expected(0);
    drive();
    drain("alt");

    // Output stall right after the header.
    rdy_val[0] = 1'b0;
    src_q[1] = '{9'h010, 9'h111};
    build_expected(0);
    drive();
    tick();
    chk("st_grant", grant[0], 4'b0010);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_hold", {tx_valid[0], tx_data[0]}, 9'h1F1);
      chk("st_ready", req_ready[0][1], 0);
    end
    rdy_val[0] = 1'b1;
    drive();
    drain("st");

    // Payload-only instance: 8 back-to-back bytes from requester 3.
    for (int i = 0; i < 8; i++)
      src_q[7].push_back({(i == 7) ? 1'b1 : 1'b0, 8'(8'h80 + i)});
    build_expected(1);
    drive();
    tick();
    chk("nh_grant", grant[1], 4'b1000);
    chk("nh_ready", req_ready[1][3], 1);
    chk("nh_valid0", tx_valid[1], 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("nh_stream_valid", tx_valid[1], 1);
    end
    tick();
    chk("nh_valid_end", tx_valid[1], 0);
    drain("nh");

    // Granted requester stalls mid-packet; grant must not move.
    src_q[0] = '{9'h020, 9'h121};
    src_q[1] = '{9'h130};
    build_expected(0);
    drive();
    tick();
    chk("lk_grant", grant[0], 4'b0001);
    tick();
    tick();
    en[0] = 1'b0;
    drive();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lk_hold", grant[0], 4'b0001);
      chk("lk_r1", req_ready[0][1], 0);
    end
    en[0] = 1'b1;
    drive();
    n = 0;
    do begin
      tick();
      n++;
    end while (grant[0] != 4'b0000 && n < 20);
    chk("lk_dead", grant[0], 0);
    tick();
    chk("lk_next", grant[0], 4'b0010);
    drain("lk");

    // Reset with a byte held in the output slot.
    rdy_val[0] = 1'b0;
    src_q[2] = '{9'h060, 9'h061, 9'h162};
    build_expected(0);
    drive();
    tick();
    tick();
    chk("rm_pre_valid", tx_valid[0], 1);
    rst = 1'b1;
    tick();
    chk("rm_valid", tx_valid[0], 0);
    chk("rm_grant", grant[0], 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) src_q[i].delete();
    exp_q[0].delete();
    exp_q[1].delete();
    rr_ptr[0] = 3;
    rr_ptr[1] = 3;
    rdy_val[0] = 1'b1;
    src_q[3] = '{9'h133};
    src_q[0] = '{9'h150};
    build_expected(0);
    drive();
    tick();
    chk("rm_win0", grant[0], 4'b0001);
    drain("rm");

    // Random packets on both instances with random back-pressure.
    rdy_rand[0] = 1'b1;
    rdy_rand[1] = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            src_q[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
        end
      end
      build_expected(0);
      build_expected(1);
      drive();
      drain($sformatf("rnd%0d", r));
      tot = 0;
      for (int i = 0; i < 8; i++) tot += src_q[i].size();
      chk("rnd_src_empty", tot, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
